shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shifter_types.sv | 20 ++
 rtl/shifter.sv | 40 ++++
 rtl/shift_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/shifter_types.sv
// Shared types for the shift sequencer: shifter command encoding and sequencer FSM states.
package shifter_types;

  localparam int DATA_W = 32;

  // Three bits wide so that unused encodings exist; they make the shifter output zero.
  typedef enum logic [2:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    ROL = 3'd2,
    ROR = 3'd3
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/shifter.sv
// Single-bit shifter step: shifts or rotates B by one position through the carry.
module shifter
  import shifter_types::*;
(
  input  cmd_t              cmd,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic [DATA_W-1:0] data,
  output logic              C
);

  // One step of the selected operation; unknown commands give zero data and zero carry.
  always_comb begin
    data = '0;
    C    = 1'b0;
    case (cmd)
      SHL: begin
        data = {B[DATA_W-2:0], 1'b0};
        C    = 1'b0;
      end
      SHR: begin
        data = {1'b0, B[DATA_W-1:1]};
        C    = 1'b0;
      end
      ROL: begin
        data = {B[DATA_W-2:0], Cin};
        C    = B[DATA_W-1];
      end
      ROR: begin
        data = {Cin, B[DATA_W-1:1]};
        C    = B[0];
      end
      default: begin
        data = '0;
        C    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: applies one shifter step per RUN cycle, count times,
// then presents the result with a one-cycle done pulse and holds it.
module shift_sequencer
  import shifter_types::*;
#(
  parameter int COUNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  cmd_t               cmd,
  input  logic [COUNT_W-1:0] count,
  input  logic [DATA_W-1:0]  din,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  dout,
  output logic               cout
);

  seq_state_t         state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               cout_q, cout_d;

  logic [DATA_W-1:0]  step_data;
  logic               step_c;

  shifter u_shifter (
    .cmd  (cmd_q),
    .B    (acc_q),
    .Cin  (carry_q),
    .data (step_data),
    .C    (step_c)
  );

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= SHL;
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic: accept in IDLE, step in RUN, publish result on entry to DONE.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d   = cmd;
          cnt_d   = count;
          acc_d   = din;
          carry_d = cin;
          if (count != '0) begin
            state_d = RUN;
          end else begin
            // Zero-length operation: the operand itself is the result.
            state_d = DONE;
            dout_d  = din;
            cout_d  = cin;
          end
        end
      end
      RUN: begin
        acc_d   = step_data;
        carry_d = step_c;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - COUNT_W'(1);
        end
        // The step taken on this edge is the last one when one step remains.
        if (cnt_q <= COUNT_W'(1)) begin
          state_d = DONE;
          dout_d  = step_data;
          cout_d  = step_c;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign dout = dout_q;
  assign cout = cout_q;

endmodule
